instr_fetch_unit: RTL and testbench

- Sequential instruction fetch front end.
- Produces the 32-bit instruction stream whose opcode field drives the main decode controller.
- Issues in-order requests to instruction memory over a valid/ready handshake and buffers returned words in a DEPTH-entry ring.
- Delivers {instruction, pc} to decode over valid/ready; redirects the fetch PC on taken branch/jump, flushing wrong-path words.

---
 rtl/instr_fetch_unit.sv | 155 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch front end: in-order memory requests, a DEPTH-entry
// ring of pending/filled words, and redirect with counted dropping of stale responses.
module instr_fetch_unit #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                DEPTH    = 2
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [31:0]       imem_rsp_data,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [31:0]       inst_data,
   output logic [ADDR_W-1:0] inst_pc,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int DROP_W = $clog2(2 * DEPTH) + 1;

   typedef enum logic [1:0] {
      E_FREE    = 2'd0,
      E_PENDING = 2'd1,
      E_FILLED  = 2'd2
   } entry_state_t;

   logic [PTR_W-1:0]  r_alloc_ptr;
   logic [PTR_W-1:0]  r_fill_ptr;
   logic [PTR_W-1:0]  r_head_ptr;
   logic [CNT_W-1:0]  r_alloc_cnt;
   logic [CNT_W-1:0]  r_pend_cnt;
   logic [DROP_W-1:0] r_drop_cnt;
   logic [ADDR_W-1:0] r_fetch_pc;

   logic [DEPTH-1:0]             w_filled;
   logic [DEPTH-1:0][ADDR_W-1:0] w_entry_pc;
   logic [DEPTH-1:0][31:0]       w_entry_data;

   logic             w_deq;
   logic [CNT_W-1:0] w_alloc_eff;
   logic             w_req_valid;
   logic             w_req_fire;
   logic             w_rsp_drop;
   logic             w_rsp_fill;

   assign inst_valid = w_filled[r_head_ptr];
   assign inst_data  = inst_valid ? w_entry_data[r_head_ptr] : '0;
   assign inst_pc    = inst_valid ? w_entry_pc[r_head_ptr]   : '0;

   // A slot handed to decode this cycle is reusable at once; without this the
   // ring would stall every third cycle with DEPTH=2 and a 1-cycle memory.
   assign w_deq       = inst_valid && inst_ready;
   assign w_alloc_eff = r_alloc_cnt - CNT_W'(w_deq);
   assign w_req_valid = !reset && !redirect && (w_alloc_eff < CNT_W'(DEPTH));
   assign w_req_fire  = w_req_valid && imem_req_ready;

   assign imem_req_valid = w_req_valid;
   assign imem_req_addr  = r_fetch_pc;

   assign w_rsp_drop = imem_rsp_valid && (r_drop_cnt != '0);
   assign w_rsp_fill = imem_rsp_valid && (r_drop_cnt == '0) && (r_pend_cnt != '0);

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      entry_state_t      r_state;
      entry_state_t      w_state_next;
      logic [ADDR_W-1:0] r_pc;
      logic [31:0]       r_data;
      logic              w_alloc_here;
      logic              w_fill_here;
      logic              w_free_here;

      assign w_alloc_here = w_req_fire && (r_alloc_ptr == PTR_W'(gi));
      assign w_fill_here  = w_rsp_fill && !redirect && (r_fill_ptr == PTR_W'(gi));
      assign w_free_here  = w_deq && (r_head_ptr == PTR_W'(gi));

      // Allocation outranks freeing: a head slot leaving and being re-claimed
      // in the same cycle must end up PENDING.
      always_comb begin
         w_state_next = r_state;
         if (redirect) begin
            w_state_next = E_FREE;
         end else if (w_alloc_here) begin
            w_state_next = E_PENDING;
         end else if (w_fill_here) begin
            w_state_next = E_FILLED;
         end else if (w_free_here) begin
            w_state_next = E_FREE;
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            r_state <= E_FREE;
         end else begin
            r_state <= w_state_next;
         end
      end

      always_ff @(posedge clk) begin
         if (w_alloc_here) begin
            r_pc <= r_fetch_pc;
         end
         if (w_fill_here) begin
            r_data <= imem_rsp_data;
         end
      end

      assign w_filled[gi]     = (r_state == E_FILLED);
      assign w_entry_pc[gi]   = r_pc;
      assign w_entry_data[gi] = r_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_alloc_ptr <= '0;
         r_fill_ptr  <= '0;
         r_head_ptr  <= '0;
         r_alloc_cnt <= '0;
         r_pend_cnt  <= '0;
         r_drop_cnt  <= '0;
         r_fetch_pc  <= RESET_PC;
      end else if (redirect) begin
         r_alloc_ptr <= '0;
         r_fill_ptr  <= '0;
         r_head_ptr  <= '0;
         r_alloc_cnt <= '0;
         r_pend_cnt  <= '0;
         // Every request still outstanding after this edge is dropped exactly once.
         r_drop_cnt  <= r_drop_cnt - DROP_W'(w_rsp_drop)
                        + DROP_W'(r_pend_cnt) - DROP_W'(w_rsp_fill);
         r_fetch_pc  <= redirect_pc & ~ADDR_W'(3);
      end else begin
         if (w_req_fire) begin
            r_alloc_ptr <= r_alloc_ptr + PTR_W'(1);
            r_fetch_pc  <= r_fetch_pc + ADDR_W'(4);
         end
         if (w_rsp_fill) begin
            r_fill_ptr <= r_fill_ptr + PTR_W'(1);
         end
         if (w_deq) begin
            r_head_ptr <= r_head_ptr + PTR_W'(1);
         end
         r_alloc_cnt <= r_alloc_cnt + CNT_W'(w_req_fire) - CNT_W'(w_deq);
         r_pend_cnt  <= r_pend_cnt + CNT_W'(w_req_fire) - CNT_W'(w_rsp_fill);
         r_drop_cnt  <= r_drop_cnt - DROP_W'(w_rsp_drop);
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory model with programmable latency and a
// scoreboard of expected {pc, data} deliveries to decode.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data  = 32'h0;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        redirect;
   logic [31:0] redirect_pc;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int mem_lat = 1;
   int n_deliv = 0;
   int r_start = 0;
   bit sb_en = 1'b0;

   logic [31:0] mem_addr_q[$];
   int          mem_due_q[$];
   logic [31:0] exp_pc_q[$];
   logic [31:0] req_log[$];
   int          deliv_cyc[$];

   instr_fetch_unit #(
      .ADDR_W  (32),
      .RESET_PC(32'h0000_0000),
      .DEPTH   (2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_req_addr (imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data (imem_rsp_data),
      .inst_valid    (inst_valid),
      .inst_ready    (inst_ready),
      .inst_data     (inst_data),
      .inst_pc       (inst_pc),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, a[15:0] + 16'h1111};
   endfunction

   // Memory model and scoreboard: drive response at +2, sample handshakes at +3.
   always begin
      @(posedge clk);
      #2;
      if (!reset && mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(mem_addr_q[0]);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end
      #1;
      if (reset) begin
         mem_addr_q.delete();
         mem_due_q.delete();
      end else begin
         if (imem_rsp_valid) begin
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
         end
         if (imem_req_valid && imem_req_ready) begin
            mem_addr_q.push_back(imem_req_addr);
            mem_due_q.push_back(cyc + mem_lat);
            req_log.push_back(imem_req_addr);
         end
         if (sb_en && inst_valid && inst_ready) begin
            logic [31:0] e;
            n_deliv++;
            deliv_cyc.push_back(cyc);
            checks++;
            if (exp_pc_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: got pc %h, expected no delivery", inst_pc);
            end else begin
               e = exp_pc_q.pop_front();
               if (inst_pc !== e) begin
                  errors++;
                  $display("FAIL sb_pc: got %h, expected %h", inst_pc, e);
               end
               checks++;
               if (inst_data !== mem_word(e)) begin
                  errors++;
                  $display("FAIL sb_data: got %h, expected %h (pc %h)", inst_data, mem_word(e), e);
               end
            end
            $display("deliver cyc=%0d pc=%h data=%h", cyc, inst_pc, inst_data);
         end
      end
      cyc++;
   end

   task automatic next_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int lat);
      next_cyc(1);
      reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
      inst_ready = 1'b0; sb_en = 1'b0; mem_lat = lat;
      next_cyc(2);
      reset = 1'b0;
      exp_pc_q.delete(); req_log.delete(); deliv_cyc.delete();
      n_deliv = 0;
      r_start = cyc;
   endtask

   task automatic wait_deliv(input int n, input int budget);
      int k = 0;
      while (n_deliv < n && k < budget) begin
         next_cyc(1);
         k++;
      end
      checks++;
      if (n_deliv < n) begin
         errors++;
         $display("FAIL deliv_timeout: got %0d deliveries, expected %0d", n_deliv, n);
      end
   endtask

   task automatic test_reset();
      next_cyc(1);
      reset = 1'b1;
      @(posedge clk); #3;
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b, expected 0", imem_req_valid); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid: got %b, expected 0", inst_valid); end
      checks++; if (inst_data !== 32'h0) begin errors++; $display("FAIL rst_inst_data: got %h, expected 0", inst_data); end
      checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL rst_inst_pc: got %h, expected 0", inst_pc); end
      checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL rst_req_addr: got %h, expected 0", imem_req_addr); end
      next_cyc(1);
      reset = 1'b0;
      #3;
      checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL rel_req_valid: got %b, expected 1", imem_req_valid); end
      $display("test_reset done");
   endtask

   task automatic test_stream();
      do_reset(1);
      sb_en = 1'b1; inst_ready = 1'b1;
      for (int i = 0; i < 24; i++) exp_pc_q.push_back(32'(4 * i));
      wait_deliv(8, 30);
      checks++;
      if (req_log.size() < 8 || deliv_cyc.size() < 8) begin
         errors++;
         $display("FAIL stream_len: got %0d reqs, expected at least 8", req_log.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (req_log[i] !== 32'(4 * i)) begin errors++; $display("FAIL stream_req%0d: got %h, expected %h", i, req_log[i], 32'(4 * i)); end
         end
         checks++;
         if (deliv_cyc[0] != r_start + 2) begin errors++; $display("FAIL stream_first: got cyc %0d, expected %0d", deliv_cyc[0], r_start + 2); end
         for (int i = 1; i < 8; i++) begin
            checks++;
            if (deliv_cyc[i] - deliv_cyc[i-1] != 1) begin errors++; $display("FAIL stream_gap%0d: got %0d cycles, expected 1", i, deliv_cyc[i] - deliv_cyc[i-1]); end
         end
      end
      sb_en = 1'b0;
      $display("test_stream done");
   endtask

   task automatic test_stall();
      do_reset(1);
      sb_en = 1'b1; inst_ready = 1'b0;
      for (int i = 0; i < 16; i++) exp_pc_q.push_back(32'(4 * i));
      next_cyc(5); #3;
      checks++;
      if (req_log.size() != 2) begin
         errors++; $display("FAIL stall_nreq: got %0d, expected 2", req_log.size());
      end else begin
         checks++; if (req_log[0] !== 32'h0) begin errors++; $display("FAIL stall_req0: got %h, expected 0", req_log[0]); end
         checks++; if (req_log[1] !== 32'h4) begin errors++; $display("FAIL stall_req1: got %h, expected 4", req_log[1]); end
      end
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_valid: got %b, expected 0", imem_req_valid); end
      checks++; if (inst_pc !== 32'h0 || inst_valid !== 1'b1) begin errors++; $display("FAIL stall_head: got valid %b pc %h, expected 1 0", inst_valid, inst_pc); end
      next_cyc(1);
      inst_ready = 1'b1;
      wait_deliv(4, 20);
      sb_en = 1'b0;
      $display("test_stall done");
   endtask

   task automatic test_redirect_inflight();
      do_reset(3);
      sb_en = 1'b1; inst_ready = 1'b1;
      for (int i = 0; i < 8; i++) exp_pc_q.push_back(32'h100 + 32'(4 * i));
      next_cyc(2);
      redirect = 1'b1; redirect_pc = 32'h100;
      #3;
      checks++; if (req_log.size() != 2) begin errors++; $display("FAIL rdi_inflight: got %0d, expected 2", req_log.size()); end
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rdi_req_blocked: got %b, expected 0", imem_req_valid); end
      next_cyc(1);
      redirect = 1'b0;
      #3;
      checks++; if (imem_req_addr !== 32'h100 || imem_req_valid !== 1'b1) begin errors++; $display("FAIL rdi_addr: got valid %b addr %h, expected 1 00000100", imem_req_valid, imem_req_addr); end
      wait_deliv(3, 30);
      sb_en = 1'b0;
      $display("test_redirect_inflight done");
   endtask

   task automatic test_redirect_with_rsp();
      do_reset(1);
      sb_en = 1'b1; inst_ready = 1'b1;
      for (int i = 0; i < 8; i++) exp_pc_q.push_back(32'h200 + 32'(4 * i));
      next_cyc(1);
      redirect = 1'b1; redirect_pc = 32'h203;
      next_cyc(1);
      redirect = 1'b0;
      #3;
      checks++; if (imem_req_addr !== 32'h200) begin errors++; $display("FAIL rdr_addr: got %h, expected 00000200", imem_req_addr); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rdr_stale: got inst_valid %b, expected 0", inst_valid); end
      wait_deliv(3, 30);
      sb_en = 1'b0;
      $display("test_redirect_with_rsp done");
   endtask

   task automatic test_back_to_back();
      do_reset(4);
      sb_en = 1'b1; inst_ready = 1'b1;
      for (int i = 0; i < 8; i++) exp_pc_q.push_back(32'h80 + 32'(4 * i));
      next_cyc(1);
      redirect = 1'b1; redirect_pc = 32'h40;
      next_cyc(1);
      redirect_pc = 32'h80;
      #3;
      checks++; if (req_log.size() != 1) begin errors++; $display("FAIL b2b_inflight: got %0d, expected 1", req_log.size()); end
      next_cyc(1);
      redirect = 1'b0;
      #3;
      checks++; if (imem_req_addr !== 32'h80) begin errors++; $display("FAIL b2b_addr: got %h, expected 00000080", imem_req_addr); end
      wait_deliv(3, 30);
      checks++;
      if (req_log.size() < 2) begin errors++; $display("FAIL b2b_req: got %0d reqs, expected at least 2", req_log.size()); end
      else if (req_log[1] !== 32'h80) begin errors++; $display("FAIL b2b_req: got %h, expected 00000080", req_log[1]); end
      sb_en = 1'b0;
      $display("test_back_to_back done");
   endtask

   task automatic test_reset_mid();
      do_reset(1);
      inst_ready = 1'b0;
      next_cyc(3); #3;
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== mem_word(32'h0)) begin errors++; $display("FAIL rm_filled: got valid %b pc %h data %h, expected 1 0 %h", inst_valid, inst_pc, inst_data, mem_word(32'h0)); end
      next_cyc(1);
      reset = 1'b1;
      next_cyc(1); #3;
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rm_inst_valid: got %b, expected 0", inst_valid); end
      checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL rm_req_addr: got %h, expected 0", imem_req_addr); end
      checks++; if (inst_pc !== 32'h0 || inst_data !== 32'h0) begin errors++; $display("FAIL rm_inst_zero: got pc %h data %h, expected 0 0", inst_pc, inst_data); end
      next_cyc(1);
      reset = 1'b0;
      exp_pc_q.delete(); req_log.delete(); deliv_cyc.delete();
      n_deliv = 0;
      sb_en = 1'b1; inst_ready = 1'b1;
      for (int i = 0; i < 16; i++) exp_pc_q.push_back(32'(4 * i));
      wait_deliv(3, 20);
      checks++;
      if (req_log.size() < 1) begin errors++; $display("FAIL rm_restart: got no requests, expected 00000000"); end
      else if (req_log[0] !== 32'h0) begin errors++; $display("FAIL rm_restart: got %h, expected 00000000", req_log[0]); end
      sb_en = 1'b0;
      $display("test_reset_mid done");
   endtask

   initial begin
      reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
      inst_ready = 1'b0; imem_req_ready = 1'b1;
      test_reset();
      test_stream();
      test_stall();
      test_redirect_inflight();
      test_redirect_with_rsp();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
